// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  // Bits captured after the start bit: 8 data, parity, stop.
  localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_FILTER_LEN     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  // Odd parity over data+parity and a high stop bit.
  function automatic logic frame_ok(input logic [PS2_SHIFT_BITS-1:0] bits);
    return (^bits[8:0]) & bits[9];
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Scan-code queue: wrap-bit pointers, combinational head read gated to zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A simultaneous pop frees a slot, so a push into a full queue still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: pin conditioning, frame deframing/checking and a read-to-pop scan-code queue.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  input  logic       keyboard_cs,
  output logic [7:0] kb_data,
  output logic       kb_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]                kclk_sync_q, kclk_sync_d;
  logic [1:0]                kdata_sync_q, kdata_sync_d;
  logic [FW-1:0]             filt_cnt_q, filt_cnt_d;
  logic                      kclk_filt_q, kclk_filt_d;
  logic                      fall_q, fall_d;
  logic                      cs_q, cs_d;

  ps2_state_e                state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [PS2_SHIFT_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      overflow_q, overflow_d;
  logic                      frame_err_q, frame_err_d;

  logic                      fifo_push;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop_req;
  logic                      pop_fire;

  // Filtered clock only follows the synchronized pin after FILTER_LEN agreeing samples.
  always_comb begin
    kclk_sync_d  = {kclk_sync_q[0], kclk};
    kdata_sync_d = {kdata_sync_q[0], kdata};
    kclk_filt_d  = kclk_filt_q;
    filt_cnt_d   = '0;
    if (kclk_sync_q[1] != kclk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) kclk_filt_d = kclk_sync_q[1];
      else                                   filt_cnt_d  = filt_cnt_q + FW'(1);
    end
    fall_d = kclk_filt_q & ~kclk_filt_d;
    cs_d   = keyboard_cs;
  end

  assign pop_req  = keyboard_cs & ~cs_q;
  assign pop_fire = pop_req & ~fifo_empty;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    timer_d     = timer_q;
    overflow_d  = overflow_q;
    frame_err_d = 1'b0;
    fifo_push   = 1'b0;

    if (pop_fire) overflow_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall_q && !kdata_sync_q[1]) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (fall_q) begin
          // LSB arrives first, so shift in from the top.
          shift_d   = {kdata_sync_q[1], shift_q[PS2_SHIFT_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'(PS2_SHIFT_BITS - 1)) state_d = ST_CHECK;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok(shift_q)) begin
          fifo_push = 1'b1;
          if (fifo_full && !pop_fire) overflow_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_sync_q  <= 2'b11;
      kdata_sync_q <= 2'b11;
      filt_cnt_q   <= '0;
      kclk_filt_q  <= 1'b1;
      fall_q       <= 1'b0;
      cs_q         <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      kclk_sync_q  <= kclk_sync_d;
      kdata_sync_q <= kdata_sync_d;
      filt_cnt_q   <= filt_cnt_d;
      kclk_filt_q  <= kclk_filt_d;
      fall_q       <= fall_d;
      cs_q         <= cs_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (shift_q[7:0]),
    .pop     (pop_req),
    .rd_data (kb_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign kb_ready  = ~fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
